// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers VGA timing from sampled hsync/vsync/RGB, measures the
// line and frame totals, locks onto stable timing and regenerates pixel
// coordinates with a qualified 3-bit pixel stream.
module vga_sync_rx #(
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        R,
  input  logic        G,
  input  logic        B,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        valid,
  output logic [2:0]  pix_rgb,
  output logic        newline,
  output logic        newframe,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        err
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [10:0] H0     = 11'(H_START);
  localparam logic [10:0] H1     = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V0     = 10'(V_START);
  localparam logic [9:0]  V1     = 10'(V_START + V_ACTIVE);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  logic        hs_s1_q, hs_s2_q, hs_prev_q;
  logic        vs_s1_q, vs_s2_q, vs_prev_q;
  logic [2:0]  rgb_s1_q, rgb_s2_q;
  logic        hs_fall, vs_fall;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] line_len;
  logic [9:0]  frame_len;
  logic        hsat;

  logic [10:0] frame_h_q;
  logic        have_h_q, frame_bad_q;
  logic [10:0] meas_h;
  logic        meas_bad, match;

  state_t      state_q;
  logic [7:0]  cnt_q, cnt_inc;
  logic [10:0] h_total_q;
  logic [9:0]  v_total_q;
  logic        locked_q, err_q;

  logic        act;
  logic [9:0]  xo, yo;
  logic [9:0]  x_q, y_q;
  logic        valid_q, newline_q, newframe_q;
  logic [2:0]  pix_q;

  assign hs_fall   = hs_prev_q & ~hs_s2_q;
  assign vs_fall   = vs_prev_q & ~vs_s2_q;
  assign line_len  = hcnt_q + 11'd1;
  assign frame_len = vcnt_q + 10'd1;
  assign hsat      = (hcnt_q == 11'h7FF) && !hs_fall;
  assign cnt_inc   = cnt_q + 8'd1;

  // The line ending on a vsync-coincident hsync fall still belongs to the
  // frame being closed, so it is folded into that frame's measurement here.
  assign meas_h   = have_h_q ? frame_h_q : line_len;
  assign meas_bad = frame_bad_q | (have_h_q & hs_fall & (line_len != frame_h_q));
  assign match    = !meas_bad && (meas_h == h_total_q) && (frame_len == v_total_q);

  // Two-flop synchronizers plus previous-value flops for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1_q   <= 1'b1;
      hs_s2_q   <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_s1_q  <= '0;
      rgb_s2_q  <= '0;
    end else begin
      hs_s1_q   <= hsync;
      hs_s2_q   <= hs_s1_q;
      hs_prev_q <= hs_s2_q;
      vs_s1_q   <= vsync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
      rgb_s1_q  <= {R, G, B};
      rgb_s2_q  <= rgb_s1_q;
    end
  end

  // Next pixel/line counts: hsync fall restarts the line, vsync fall the frame.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hs_fall) begin
      hcnt_d = '0;
    end else if (hcnt_q != 11'h7FF) begin
      hcnt_d = hcnt_q + 11'd1;
    end
    if (vs_fall) begin
      vcnt_d = '0;
    end else if (hs_fall && (vcnt_q != 10'h3FF)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  // Position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Per-frame line-length consistency: first line sets the frame's length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_h_q   <= '0;
      have_h_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else if (vs_fall) begin
      have_h_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else if (hs_fall) begin
      if (!have_h_q) begin
        frame_h_q <= line_len;
        have_h_q  <= 1'b1;
      end else if (line_len != frame_h_q) begin
        frame_bad_q <= 1'b1;
      end
    end
  end

  // Lock FSM: reference capture, match counting and loss-of-lock reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      cnt_q     <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (hsat) begin
        if (state_q == LOCKED) err_q <= 1'b1;
        state_q  <= SEARCH;
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else if (vs_fall) begin
        case (state_q)
          SEARCH: begin
            state_q <= TRACK;
            cnt_q   <= '0;
          end
          TRACK: begin
            if (match) begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              h_total_q <= meas_h;
              v_total_q <= frame_len;
              cnt_q     <= 8'd1;
              if (8'd1 >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (!match) begin
              err_q     <= 1'b1;
              locked_q  <= 1'b0;
              state_q   <= TRACK;
              h_total_q <= meas_h;
              v_total_q <= frame_len;
              cnt_q     <= 8'd1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  // Coordinates come from the next-count values, which describe the sample
  // currently in the second sync flop. Lock changes only happen at line
  // starts or after saturation, never inside the active window, so gating
  // with the registered lock flag is exact.
  assign act = (hcnt_d >= H0) && (hcnt_d < H1) && (vcnt_d >= V0) && (vcnt_d < V1);
  assign xo  = 10'(hcnt_d - H0);
  assign yo  = vcnt_d - V0;

  // Registered pixel outputs and line/frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      pix_q      <= '0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
    end else begin
      valid_q    <= act & locked_q;
      x_q        <= (act & locked_q) ? xo : '0;
      y_q        <= (act & locked_q) ? yo : '0;
      pix_q      <= (act & locked_q) ? rgb_s2_q : '0;
      newline_q  <= hs_fall;
      newframe_q <= vs_fall;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign valid    = valid_q;
  assign pix_rgb  = pix_q;
  assign newline  = newline_q;
  assign newframe = newframe_q;
  assign locked   = locked_q;
  assign h_total  = h_total_q;
  assign v_total  = v_total_q;
  assign err      = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives scaled-down VGA frames with random pixel data and
// compares every output against a frame-level model of the lock rules.
module tb_vga_sync_rx;

  localparam int HSW  = 4;   // hsync low width
  localparam int HST  = 8;   // first active column
  localparam int HA   = 16;
  localparam int HT   = 28;
  localparam int VSW  = 2;   // vsync low lines
  localparam int VST  = 3;
  localparam int VA   = 6;
  localparam int VT   = 11;
  localparam int LOCKN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic        R = 1'b0, G = 1'b0, B = 1'b0;
  logic [9:0]  x, y;
  logic        valid;
  logic [2:0]  pix_rgb;
  logic        newline, newframe, locked;
  logic [10:0] h_total;
  logic [9:0]  v_total;
  logic        err;

  vga_sync_rx #(
    .H_START(HST), .V_START(VST), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .R(R), .G(G), .B(B),
    .x(x), .y(y), .valid(valid), .pix_rgb(pix_rgb), .newline(newline),
    .newframe(newframe), .locked(locked), .h_total(h_total), .v_total(v_total),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Frame-level model of the lock rules.
  bit m_searching = 1'b1;
  bit m_locked    = 1'b0;
  int m_count     = 0;
  int m_ref_h     = 0;
  int m_ref_v     = 0;
  int p_h = 0, p_v = 0;
  bit p_bad = 1'b0;
  bit frame_full_lock = 1'b0;
  int obs_valid = 0;

  logic [48:0] pe [3];
  bit          ph [3];

  task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errs++;
      $display("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp_v);
    end
  endtask

  function automatic logic [48:0] obs_vec();
    return {valid, x, y, pix_rgb, locked, err, newline, newframe, h_total, v_total};
  endfunction

  // One pixel clock: check the output of the sample driven three clocks ago,
  // then drive the next sample.
  task automatic step(input logic hs, input logic vs, input logic [2:0] rgb,
                      input bit has, input logic [48:0] e);
    @(posedge clk);
    #1;
    if (valid) obs_valid++;
    if (ph[2]) chk("pix", obs_vec(), pe[2]);
    pe[2] = pe[1]; ph[2] = ph[1];
    pe[1] = pe[0]; ph[1] = ph[0];
    pe[0] = e;     ph[0] = has;
    hsync = hs;
    vsync = vs;
    {R, G, B} = rgb;
  endtask

  // Decision taken when the previous frame (p_*) is closed by a vsync fall.
  task automatic frame_boundary(output bit e);
    bit match;
    e = 1'b0;
    match = !p_bad && (p_h == m_ref_h) && (p_v == m_ref_v);
    if (m_searching) begin
      m_searching = 1'b0;
      m_count = 0;
    end else if (!m_locked) begin
      if (match) m_count++;
      else begin
        m_ref_h = p_h; m_ref_v = p_v; m_count = 1;
      end
      if (m_count >= LOCKN) m_locked = 1'b1;
    end else if (!match) begin
      e = 1'b1;
      m_locked = 1'b0;
      m_ref_h = p_h; m_ref_v = p_v; m_count = 1;
    end
    frame_full_lock = m_locked;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async", obs_vec(), '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_hold", obs_vec(), '0);
    rst = 1'b0;
    hsync = 1'b1; vsync = 1'b1; {R, G, B} = 3'b000;
    for (int i = 0; i < 3; i++) ph[i] = 1'b0;
    m_searching = 1'b1; m_locked = 1'b0; m_count = 0;
    m_ref_h = 0; m_ref_v = 0;
    frame_full_lock = 1'b0;
    obs_valid = 0;
  endtask

  // One source frame. bad_line gets length bad_len, the last line is
  // stretched by tail_len, corner draws only the two corner pixels, and
  // rst_at (>0) resets the DUT after that many samples.
  task automatic send_frame(input int bad_line, input int bad_len, input int tail_len,
                            input bit corner, input int rst_at);
    int n = 0;
    int fh = 0;
    bit fbad = 1'b0;
    if (frame_full_lock) chk("nvalid", 49'(obs_valid), 49'(HA * VA));
    obs_valid = 0;
    for (int v = 0; v < VT; v++) begin
      int len;
      len = (v == bad_line) ? bad_len : HT;
      if (v == VT - 1) len += tail_len;
      if (v == 0) fh = len;
      else if (len != fh) fbad = 1'b1;
      for (int h = 0; h < len; h++) begin
        bit e_err, act, vexp;
        logic [2:0] rgb;
        logic [48:0] e;
        e_err = 1'b0;
        if (h == 0 && v == 0) frame_boundary(e_err);
        if (h == 2048) begin
          if (m_locked) e_err = 1'b1;
          m_locked = 1'b0;
          m_searching = 1'b1;
          frame_full_lock = 1'b0;
        end
        act = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
        if (corner)
          rgb = (act && h == HST && v == VST) ? 3'b100 :
                (act && h == HST + HA - 1 && v == VST + VA - 1) ? 3'b001 : 3'b000;
        else
          rgb = act ? 3'($urandom_range(0, 7)) : 3'b000;
        vexp = m_locked && act;
        e = {vexp, vexp ? 10'(h - HST) : 10'd0, vexp ? 10'(v - VST) : 10'd0,
             vexp ? rgb : 3'b000, m_locked, e_err, (h == 0), (h == 0 && v == 0),
             11'(m_ref_h), 10'(m_ref_v)};
        step((h < HSW) ? 1'b0 : 1'b1, (v < VSW) ? 1'b0 : 1'b1, rgb, 1'b1, e);
        n++;
        if (n == rst_at) begin
          do_reset();
          return;
        end
      end
    end
    p_h = fh; p_v = VT; p_bad = fbad;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) ph[i] = 1'b0;
    #12;
    chk("reset", obs_vec(), '0);
    #10;
    rst = 1'b0;

    // Nominal lock-up: locked from the 3rd vsync fall onward.
    repeat (4) send_frame(-1, 0, 0, 1'b0, -1);
    send_frame(-1, 0, 0, 1'b1, -1);

    // One longer line mid-frame, then clean frames.
    send_frame($urandom_range(2, VT - 2), HT + 1, 0, 1'b0, -1);
    repeat (3) send_frame(-1, 0, 0, 1'b0, -1);

    // Longer first line: the reference itself is corrupted for one frame.
    send_frame(0, HT + 1, 0, 1'b0, -1);
    repeat (3) send_frame(-1, 0, 0, 1'b0, -1);

    // hsync missing for over 2048 clocks while locked.
    send_frame(-1, 0, 2100, 1'b0, -1);
    repeat (4) send_frame(-1, 0, 0, 1'b0, -1);

    // Reset somewhere mid-line while locked, then relock.
    send_frame(-1, 0, 0, 1'b0, $urandom_range(HT * 4 + 5, HT * 7 - 3));
    repeat (4) send_frame(-1, 0, 0, 1'b0, -1);
    send_frame(-1, 0, 0, 1'b1, -1);

    repeat (3) step(1'b1, 1'b1, 3'b000, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side VGA timing recovery block: samples the hsync/vsync/R/G/B lines a VGA timing generator drives, measures line and frame totals, locks once timing is stable, and regenerates pixel coordinates with a qualified 3-bit pixel stream. It is used in loopback self-test and as the front end of any capture path fed by the VGA output. It runs on the 25 MHz pixel clock, one sample per pixel.

## Interface
- H_START, 144: hcnt value of the first active pixel (hsync width + back porch).
- V_START, 35: vcnt value of the first active line.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive matching frames required to lock.
- clk  in  1  pixel clock. One clock domain.
- rst  in  1  reset, asynchronous, active-high.
- hsync  in  1  horizontal sync, active-low.
- vsync  in  1  vertical sync, active-low.
- R, G, B  in  1 each  pixel colour.
- x  out  10  active-pixel column, 0..639; 0 when valid=0.
- y  out  10  active-pixel row, 0..479; 0 when valid=0.
- valid  out  1  pix_rgb/x/y are an active pixel and locked=1.
- pix_rgb  out  3  {R,G,B} aligned with x/y.
- newline  out  1  one-cycle pulse per detected hsync falling edge.
- newframe  out  1  one-cycle pulse per detected vsync falling edge.
- locked  out  1  timing locked.
- h_total  out  11  reference line length in clocks (valid when locked).
- v_total  out  10  reference frame length in lines.
- err  out  1  one-cycle pulse on loss of lock.

## Operation
- Input stage: hsync, vsync, R, G, B each pass through a 2-flop synchronizer; edge detect on synchronized hsync/vsync (previous=1, current=0).
- hcnt (11 bit): cleared to 0 on hsync fall, else +1, saturating at 2047. Line length measured = hcnt+1 at the fall.
- vcnt (10 bit): cleared to 0 on vsync fall; else +1 on hsync fall; saturates at 1023. Simultaneous vsync and hsync fall: vcnt=0 (vsync wins).
- Per-frame check: first measured line length of a frame stored as frame_h; any later line length != frame_h sets frame_bad. Frame length = vcnt+1 at vsync fall.
- FSM states SEARCH, TRACK, LOCKED; reset to SEARCH.
  - SEARCH: on vsync fall -> TRACK, match count=0.
  - TRACK, at vsync fall: if !frame_bad and (frame_h, frame length) == (h_total, v_total) then count+1, else reference <= measured and count=1. count reaching LOCK_FRAMES -> LOCKED.
  - LOCKED, at vsync fall: mismatch or frame_bad -> err pulse, reference <= measured, count=1, -> TRACK.
  - Any state: hcnt saturating at 2047 (no hsync) -> SEARCH; err pulses if leaving LOCKED.
- Active region: H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE; x = hcnt-H_START, y = vcnt-V_START. valid = active and locked.

## Timing
- Reset: x, y, pix_rgb, h_total, v_total = 0; valid, newline, newframe, locked, err = 0; FSM SEARCH; counters 0.
- All outputs registered. Input sample at cycle t -> pix_rgb/x/y/valid at t+3 (2 sync + 1 output register).
- newline/newframe assert 1 cycle after the synchronized edge is seen; hcnt reads 0 in that same cycle.
- locked rises and err pulses in the cycle after the deciding vsync fall is detected; locked falls in the same cycle err pulses.
- Reset mid-frame: outputs clear immediately; lock sequence restarts from SEARCH.

## Test plan
- Nominal 800x525 stream (hsync 96 low, vsync 2 lines low) -> locked=1 after 3rd vsync fall; h_total=800, v_total=525; err never pulses.
- Source drives R=1 only at its pixel (0,0) and B=1 only at (639,479) -> pix_rgb=3'b100 with x=0,y=0,valid=1 and 3'b001 with x=639,y=479; exactly 307200 valid cycles per frame.
- While locked, one line lengthened to 801 -> err pulse and locked=0 at next vsync fall; locked back to 1 after 2 further clean frames.
- hsync held high 2048+ cycles while locked -> err pulse, FSM SEARCH, valid=0; relock after 3 vsync falls once restored.
- Assert rst mid-line in LOCKED -> all outputs 0 immediately; relock follows nominal sequence.
- vsync fall coincident with hsync fall -> vcnt=0, newline and newframe pulse same cycle.
